// File: rtl/servo_pd_sequencer.sv
// Servo PD loop sample scheduler: sensor request, term-unit compute pulse, saturated u to PWM.
// Optional deadband on u when SERVO_SEQ_DEADBAND_EN is defined.
module servo_pd_sequencer #(
    parameter int SAMPLE_DIV = 50000,
    parameter int TERM_LAT   = 1,
    parameter int Y_TIMEOUT  = 255,
    parameter int SHIFT      = 6,
    parameter int UW         = 12,
    parameter int DEADBAND   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 yk_req,
    input  logic signed [8:0]    yk_in,
    input  logic                 yk_in_valid,
    output logic signed [8:0]    yk,
    output logic signed [8:0]    yk1,
    output logic                 compute,
    input  logic signed [18:0]   pk,
    input  logic signed [18:0]   dk,
    output logic signed [UW-1:0] u,
    output logic                 u_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 fault
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW = $clog2(Y_TIMEOUT + 1);
    localparam int LW = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ       = 3'd1;
    localparam logic [2:0] S_WAIT_Y    = 3'd2;
    localparam logic [2:0] S_COMPUTE   = 3'd3;
    localparam logic [2:0] S_WAIT_TERM = 3'd4;
    localparam logic [2:0] S_SUM       = 3'd5;

    localparam int                 U_MAX_I = 2 ** (UW - 1) - 1;
    localparam logic signed [19:0] U_MAX   = 20'(U_MAX_I);
    localparam logic signed [19:0] U_MIN   = 20'(-U_MAX_I - 1);

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [LW-1:0]        lat_q, lat_d;
    logic                 prime_q, prime_d;
    logic signed [8:0]    yk_q, yk_d;
    logic signed [8:0]    yk1_q, yk1_d;
    logic signed [UW-1:0] u_q, u_d;
    logic                 overrun_q, overrun_d;
    logic                 fault_q, fault_d;

    logic                 tick;
    logic signed [19:0]   s_diff;
    logic signed [19:0]   t_shift;
    logic signed [19:0]   t_sat;
    logic signed [UW-1:0] u_next;

    assign tick = en && (cnt_q == CW'(SAMPLE_DIV - 1));

    always_comb begin
        s_diff  = {pk[18], pk} - {dk[18], dk};
        t_shift = s_diff >>> SHIFT;
        if (t_shift > U_MAX) begin
            t_sat = U_MAX;
        end else if (t_shift < U_MIN) begin
            t_sat = U_MIN;
        end else begin
            t_sat = t_shift;
        end
        u_next = t_sat[UW-1:0];
`ifdef SERVO_SEQ_DEADBAND_EN
        if ((t_sat > -20'(DEADBAND)) && (t_sat < 20'(DEADBAND))) begin
            u_next = '0;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (!en || tick) ? '0 : cnt_q + CW'(1);
        tmo_d     = tmo_q;
        lat_d     = lat_q;
        prime_d   = prime_q;
        yk_d      = yk_q;
        yk1_d     = yk1_q;
        u_d       = u_q;
        fault_d   = fault_q;
        // A tick landing on the SUM cycle starts the next sample, so it is not an overrun.
        overrun_d = overrun_q | (tick && (state_q != S_IDLE) && (state_q != S_SUM));

        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_REQ;
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                if (yk_in_valid) begin
                    yk_d    = yk_in;
                    yk1_d   = prime_q ? yk_q : yk_in;
                    prime_d = 1'b1;
                    state_d = S_COMPUTE;
                end else if (tmo_q == TW'(Y_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_COMPUTE: begin
                lat_d   = '0;
                state_d = S_WAIT_TERM;
            end
            S_WAIT_TERM: begin
                // pk/dk become valid on the last WAIT_TERM cycle; u is latched here so
                // that u_valid (the SUM cycle) lands TERM_LAT+1 cycles after compute.
                if (lat_q == LW'(TERM_LAT - 1)) begin
                    u_d     = u_next;
                    state_d = S_SUM;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_SUM: begin
                state_d = tick ? S_REQ : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!en) prime_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            lat_q     <= '0;
            prime_q   <= 1'b0;
            yk_q      <= '0;
            yk1_q     <= '0;
            u_q       <= '0;
            overrun_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            lat_q     <= lat_d;
            prime_q   <= prime_d;
            yk_q      <= yk_d;
            yk1_q     <= yk1_d;
            u_q       <= u_d;
            overrun_q <= overrun_d;
            fault_q   <= fault_d;
        end
    end

    assign yk_req  = (state_q == S_REQ);
    assign compute = (state_q == S_COMPUTE);
    assign u_valid = (state_q == S_SUM);
    assign busy    = (state_q != S_IDLE);
    assign yk      = yk_q;
    assign yk1     = yk1_q;
    assign u       = u_q;
    assign overrun = overrun_q;
    assign fault   = fault_q;

endmodule
